// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared constants, FSM states and domain bytes for the SHA3 absorb block (option: SHA3_LEGACY_KECCAK_EN)
package sha3_pkg;

  localparam int RATE_BYTES = 136;
  localparam int RATE_LANES = 17;
  localparam int BEATS      = 8;
  localparam int BEAT_W     = 200;
  localparam int STATE_W    = BEATS * BEAT_W;
  localparam int RATE_W     = RATE_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_SEND,
    ST_WAIT,
    ST_DIGEST
  } state_e;

  // Domain-separation bytes: SHA3-256 appends 01 then pad10*1, Keccak-256 only pad10*1.
  localparam logic [7:0] DOM_SHA3   = 8'h06;
  localparam logic [7:0] DOM_KECCAK = 8'h01;
  localparam logic [7:0] PAD_END    = 8'h80;

`ifdef SHA3_LEGACY_KECCAK_EN
  localparam bit LEGACY_KECCAK = 1'b1;
`else
  localparam bit LEGACY_KECCAK = 1'b0;
`endif

  localparam logic [7:0] DOMAIN_BYTE = LEGACY_KECCAK ? DOM_KECCAK : DOM_SHA3;

endpackage

// File: rtl/sha3_pad_mask.sv
// rtl/sha3_pad_mask.sv - padding XOR mask over the rate for a given message byte position
module sha3_pad_mask
  import sha3_pkg::*;
(
  input  logic [7:0]        p_i,
  output logic [RATE_W-1:0] mask_o
);

  // Domain byte at position p, final pad bit at byte 135; both land in the same byte when p=135.
  always_comb begin
    mask_o = (RATE_W'(DOMAIN_BYTE) << {p_i, 3'b000}) ^ {PAD_END, {(RATE_W-8){1'b0}}};
  end

endmodule

// File: rtl/sha3_absorb.sv
// rtl/sha3_absorb.sv - SHA3-256 absorb/pad front end feeding an external Keccak-f engine (option: SHA3_LEGACY_KECCAK_EN)
module sha3_absorb
  import sha3_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         msg_valid,
  input  logic [63:0]  msg_data,
  input  logic         msg_last,
  input  logic [3:0]   msg_bytes,
  output logic         msg_ready,
  output logic         pushout,
  output logic [2:0]   doutix,
  output logic [199:0] dout,
  input  logic         pushin,
  input  logic [2:0]   dix,
  input  logic [199:0] din,
  output logic         digest_valid,
  output logic [255:0] digest,
  input  logic         digest_ready
);

  state_e             state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [4:0]         w_q, w_d;
  logic [2:0]         beat_q, beat_d;
  logic [7:0]         p_q, p_d;
  logic               pad_pend_q, pad_pend_d;
  logic               done_q, done_d;

  logic [RATE_W-1:0]  pad_mask;
  logic [3:0]         nbytes;
  logic [7:0]         p_calc;
  logic [63:0]        word_mask;
  logic [10:0]        lane_off;
  logic [10:0]        send_off;
  logic [10:0]        wait_off;

  sha3_pad_mask u_pad_mask (
    .p_i    (p_q),
    .mask_o (pad_mask)
  );

  assign lane_off = {w_q, 6'b000000};
  assign send_off = 11'(beat_q) * 11'(BEAT_W);
  assign wait_off = 11'(dix) * 11'(BEAT_W);

  // Valid-byte count of the offered word, resulting byte position and byte-lane mask
  always_comb begin
    if (!msg_last || msg_bytes > 4'd8) nbytes = 4'd8;
    else                               nbytes = msg_bytes;
    p_calc    = {w_q, 3'b000} + {4'b0000, nbytes};
    word_mask = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < nbytes) word_mask[8*b +: 8] = 8'hff;
    end
  end

  // State register; reset wipes every bit of absorbed progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      w_q        <= '0;
      beat_q     <= '0;
      p_q        <= '0;
      pad_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      w_q        <= w_d;
      beat_q     <= beat_d;
      p_q        <= p_d;
      pad_pend_q <= pad_pend_d;
      done_q     <= done_d;
    end
  end

  // Next state, state datapath and all outputs decoded from the current state
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    w_d          = w_q;
    beat_d       = beat_q;
    p_d          = p_q;
    pad_pend_d   = pad_pend_q;
    done_d       = done_q;
    msg_ready    = 1'b0;
    pushout      = 1'b0;
    doutix       = '0;
    dout         = '0;
    digest_valid = 1'b0;
    digest       = '0;

    unique case (state_q)
      ST_IDLE: state_d = ST_ABSORB;

      ST_ABSORB: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          s_d[lane_off +: 64] = s_q[lane_off +: 64] ^ (msg_data & word_mask);
          if (msg_last) begin
            done_d = 1'b1;
            w_d    = '0;
            if (p_calc < 8'(RATE_BYTES)) begin
              p_d     = p_calc;
              state_d = ST_PAD;
            end else begin
              // Block exactly full: permute it first, padding goes into a fresh block.
              pad_pend_d = 1'b1;
              beat_d     = '0;
              state_d    = ST_SEND;
            end
          end else if (w_q == 5'(RATE_LANES - 1)) begin
            w_d     = '0;
            beat_d  = '0;
            state_d = ST_SEND;
          end else begin
            w_d = w_q + 5'd1;
          end
        end
      end

      ST_PAD: begin
        s_d[RATE_W-1:0] = s_q[RATE_W-1:0] ^ pad_mask;
        beat_d          = '0;
        state_d         = ST_SEND;
      end

      ST_SEND: begin
        pushout = 1'b1;
        doutix  = beat_q;
        dout    = s_q[send_off +: BEAT_W];
        beat_d  = beat_q + 3'd1;
        if (beat_q == 3'(BEATS - 1)) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (pushin) begin
          s_d[wait_off +: BEAT_W] = din;
          if (dix == 3'(BEATS - 1)) begin
            if (pad_pend_q) begin
              pad_pend_d = 1'b0;
              p_d        = '0;
              state_d    = ST_PAD;
            end else if (done_q) begin
              state_d = ST_DIGEST;
            end else begin
              state_d = ST_ABSORB;
            end
          end
        end
      end

      ST_DIGEST: begin
        digest_valid = 1'b1;
        digest       = s_q[255:0];
        if (digest_ready) begin
          s_d     = '0;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
